// File: rtl/pwm_meter.sv
// Measures period, high time and duty cycle of an asynchronous PWM input,
// flagging a stuck input after TIMEOUT cycles without a rising edge.
module pwm_meter #(
  parameter int WIDTH   = 26,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic [6:0]       duty,
  output logic             valid,
  output logic             stuck
);
  localparam int NW = WIDTH + 7;
  localparam int BW = $clog2(NW);
  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;
  state_t state_reg, state_next;

  logic             sync1_reg, pwm_s_reg, pwm_d_reg;
  logic [WIDTH-1:0] cnt_reg, hi_lat_reg, per_reg, rem_reg;
  logic [NW-1:0]    num_reg, quo_reg;
  logic [BW-1:0]    bit_reg;

  logic             rise, fall, timeout, div_done, ge;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic [NW-1:0]    quo_next;
  logic [6:0]       duty_sat;

  // The synchronizer keeps running while disabled so no edge is invented on re-enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      pwm_s_reg <= 1'b0;
      pwm_d_reg <= 1'b0;
    end else begin
      sync1_reg <= pwm_in;
      pwm_s_reg <= sync1_reg;
      pwm_d_reg <= pwm_s_reg;
    end
  end

  assign rise = pwm_s_reg & ~pwm_d_reg;
  assign fall = ~pwm_s_reg & pwm_d_reg;

  // Once stuck is reported from IDLE, the held count must not report again.
  assign timeout  = (cnt_reg == TMO) && !rise &&
                    (state_reg == MEASURE || (state_reg == IDLE && !stuck));
  assign div_done = (state_reg == DIVIDE) && (bit_reg == '0);

  // One restoring division step: bring down the next numerator bit.
  assign trial    = {rem_reg, num_reg[NW-1]};
  assign ge       = trial >= {1'b0, per_reg};
  assign diff     = trial[WIDTH-1:0] - per_reg;
  assign quo_next = {quo_reg[NW-2:0], ge};
  assign duty_sat = (quo_next > NW'(100)) ? 7'd100 : quo_next[6:0];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (enable) begin
      case (state_reg)
        IDLE:    if (rise) state_next = MEASURE;
        MEASURE: begin
          if (rise)         state_next = DIVIDE;
          else if (timeout) state_next = IDLE;
        end
        DIVIDE:  if (div_done) state_next = MEASURE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      hi_lat_reg <= '0;
      per_reg    <= '0;
      rem_reg    <= '0;
      num_reg    <= '0;
      quo_reg    <= '0;
      bit_reg    <= '0;
      period     <= '0;
      high_time  <= '0;
      duty       <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (enable) begin
        if (rise)                 cnt_reg <= WIDTH'(1);
        else if (cnt_reg != TMO)  cnt_reg <= cnt_reg + 1'b1;

        if (fall && state_reg != IDLE) hi_lat_reg <= cnt_reg;

        if (state_reg == MEASURE && rise) begin
          per_reg <= cnt_reg;
          num_reg <= NW'(hi_lat_reg) * NW'(100);
          rem_reg <= '0;
          quo_reg <= '0;
          bit_reg <= BW'(NW - 1);
        end

        if (state_reg == DIVIDE) begin
          rem_reg <= ge ? diff : trial[WIDTH-1:0];
          num_reg <= num_reg << 1;
          quo_reg <= quo_next;
          bit_reg <= bit_reg - 1'b1;
          if (div_done) begin
            period    <= per_reg;
            high_time <= hi_lat_reg;
            duty      <= duty_sat;
            valid     <= 1'b1;
            stuck     <= 1'b0;
          end
        end

        if (timeout) begin
          period    <= '0;
          high_time <= '0;
          duty      <= pwm_s_reg ? 7'd100 : 7'd0;
          valid     <= 1'b1;
          stuck     <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_meter.sv
// Directed bench for pwm_meter: square waves, floor/saturation cases, stuck
// detection, enable freeze, reset during division and over-short periods.
module tb_pwm_meter;
  logic        clk = 1'b0;
  logic        reset, enable, pwm_in;
  logic [25:0] period, high_time;
  logic [6:0]  duty;
  logic        valid, stuck;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int vcount = 0;
  int last_valid_cyc = 0;
  int last_raise = 0;
  int snap;

  pwm_meter #(.WIDTH(26), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .duty(duty),
    .valid(valid), .stuck(stuck)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid) begin
    vcount <= vcount + 1;
    last_valid_cyc <= cyc;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end else
      $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      last_raise = cyc;
      tick(hi);
      pwm_in = 1'b0;
      tick(per - hi);
    end
  endtask

  task automatic check_out(input string tag, input int p, input int h, input int d, input int s);
    check_eq({tag, " period"}, int'(period), p);
    check_eq({tag, " high_time"}, int'(high_time), h);
    check_eq({tag, " duty"}, int'(duty), d);
    check_eq({tag, " stuck"}, int'(stuck), s);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; pwm_in = 1'b0;
    tick(3);
    check_out("reset", 0, 0, 0, 0);
    check_eq("reset valid", int'(valid), 0);
    reset = 1'b0;

    // 100/25: first rise only arms, each later rise reports 34 cycles after detection
    wave(100, 25, 4);
    check_out("sq100_25", 100, 25, 25, 0);
    check_eq("sq100_25 valids", vcount, 3);
    check_eq("latency", last_valid_cyc - last_raise, 36);

    wave(300, 100, 2);
    check_out("p300_h100", 300, 100, 33, 0);

    wave(200, 199, 2);
    check_out("p200_h199", 200, 199, 99, 0);

    // stuck high: one more measurement report, then exactly one timeout report
    pwm_in = 1'b1;
    tick(100);
    snap = vcount;
    tick(1100);
    check_out("stuck_hi", 0, 0, 100, 1);
    check_eq("stuck_hi valids", vcount - snap, 1);

    pwm_in = 1'b0;
    tick(20);
    wave(100, 50, 3);
    check_out("resume50", 100, 50, 50, 0);

    snap = vcount;
    tick(1200);
    check_out("stuck_lo", 0, 0, 0, 1);
    check_eq("stuck_lo valids", vcount - snap, 1);

    // enable low for 500 cycles while pwm is high: count frozen, outputs held
    wave(100, 40, 2);
    pwm_in = 1'b1;
    tick(60);
    snap = vcount;
    enable = 1'b0;
    tick(500);
    check_out("disabled", 100, 40, 40, 0);
    check_eq("disabled valids", vcount - snap, 0);
    enable = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(30);
    pwm_in = 1'b1;
    tick(60);
    check_out("frozen_cnt", 100, 70, 70, 0);

    // reset 10 cycles after a rise, with pwm already low
    pwm_in = 1'b0;
    tick(40);
    snap = vcount;
    pwm_in = 1'b1;
    tick(5);
    pwm_in = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_out("mid_div_reset", 0, 0, 0, 0);
    tick(89);
    check_eq("mid_div_reset valids", vcount - snap, 0);
    wave(100, 30, 2);
    check_out("after_reset", 100, 30, 30, 0);
    check_eq("after_reset valids", vcount - snap, 1);

    // period 20: rises during the division are dropped
    snap = vcount;
    wave(20, 10, 10);
    check_eq("p20 valids", vcount - snap, 5);
    snap = vcount;
    wave(100, 50, 3);
    check_eq("p100_after_p20 valids", vcount - snap, 3);
    check_out("p100_after_p20", 100, 50, 50, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
